// File: rtl/pwm_preconditioner.sv
// pwm_preconditioner
// Turns per-channel (cycle, duty, phase) triples from the silencer into the
// rise/fall compare times used by the per-transducer PWM generators.
// Channels go one per clock through a three-stage pipeline. DOUT_VALID
// pulses once every RISE/FALL entry has been rewritten.

module pwm_preconditioner #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 249
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DIN_VALID,
  input  logic [WIDTH-1:0] CYCLE [0:DEPTH-1],
  input  logic [WIDTH-1:0] DUTY  [0:DEPTH-1],
  input  logic [WIDTH-1:0] PHASE [0:DEPTH-1],
  output logic [WIDTH-1:0] RISE  [0:DEPTH-1],
  output logic [WIDTH-1:0] FALL  [0:DEPTH-1],
  output logic             DOUT_VALID
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned W1    = WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       drain_cnt_q, drain_cnt_d;
  logic             pending_q, pending_d;
  logic             dout_valid_d;
  logic             issue;

  // Stage 0 registers: raw channel values fetched at idx
  logic             s0_vld;
  logic [IDX_W-1:0] s0_ch;
  logic [WIDTH-1:0] s0_c, s0_d, s0_p;

  // Stage 1 registers: clamped phase/duty and duty halves
  logic             s1_vld;
  logic [IDX_W-1:0] s1_ch;
  logic [W1-1:0]    s1_c, s1_p, s1_lo, s1_hi;
  logic             s1_zero, s1_full;

  // Stage 1 combinational results
  logic [W1-1:0]    c_w, d_raw_w, ph_w, p_w, d_w, lo_w, hi_w;

  // Stage 2 combinational results
  logic [W1-1:0]    f_sum;
  logic [WIDTH-1:0] rise_n, fall_n;

  // FSM state, channel index, drain counter, pending flag and done pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      drain_cnt_q <= '0;
      pending_q   <= 1'b0;
      DOUT_VALID  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      drain_cnt_q <= drain_cnt_d;
      pending_q   <= pending_d;
      DOUT_VALID  <= dout_valid_d;
    end
  end

  // Next-state logic. DRAIN counts 0..3: counts 0-1 let the pipeline empty,
  // the step out of count 2 raises DOUT_VALID, and the step out of count 3
  // (the DOUT_VALID cycle) restarts at idx 0 if a strobe arrived meanwhile.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    drain_cnt_d  = drain_cnt_q;
    pending_d    = pending_q;
    dout_valid_d = 1'b0;
    issue        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (DIN_VALID) begin
          state_d   = RUN;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (DIN_VALID) pending_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        if (DIN_VALID) pending_d = 1'b1;
        if (drain_cnt_q == 2'd3) begin
          if (pending_q || DIN_VALID) begin
            state_d   = RUN;
            idx_d     = '0;
            pending_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
          if (drain_cnt_q == 2'd2) dout_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stage 0: capture the live inputs of the channel being issued
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s0_vld <= 1'b0;
      s0_ch  <= '0;
      s0_c   <= '0;
      s0_d   <= '0;
      s0_p   <= '0;
    end else begin
      s0_vld <= issue;
      if (issue) begin
        s0_ch <= idx_q;
        s0_c  <= CYCLE[idx_q];
        s0_d  <= DUTY[idx_q];
        s0_p  <= PHASE[idx_q];
      end
    end
  end

  // Stage 1 combinational: fold phase into one period, clamp duty, split duty
  always_comb begin
    c_w     = {1'b0, s0_c};
    d_raw_w = {1'b0, s0_d};
    ph_w    = {1'b0, s0_p};
    p_w     = (ph_w >= c_w) ? ph_w - c_w : ph_w;
    d_w     = (d_raw_w > c_w) ? c_w : d_raw_w;
    lo_w    = d_w >> 1;
    hi_w    = d_w - lo_w;
  end

  // Stage 1 register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_vld  <= 1'b0;
      s1_ch   <= '0;
      s1_c    <= '0;
      s1_p    <= '0;
      s1_lo   <= '0;
      s1_hi   <= '0;
      s1_zero <= 1'b0;
      s1_full <= 1'b0;
    end else begin
      s1_vld <= s0_vld;
      if (s0_vld) begin
        s1_ch   <= s0_ch;
        s1_c    <= c_w;
        s1_p    <= p_w;
        s1_lo   <= lo_w;
        s1_hi   <= hi_w;
        // c == 0 forces the clamped duty to 0, so it lands in the zero case
        s1_zero <= (d_w == '0);
        s1_full <= (d_w == c_w);
      end
    end
  end

  // Stage 2 combinational: centre the pulse on the phase and wrap into [0,c)
  always_comb begin
    f_sum  = s1_p + s1_hi;
    rise_n = '0;
    fall_n = '0;
    if (s1_zero) begin
      rise_n = '0;
      fall_n = '0;
    end else if (s1_full) begin
      rise_n = '0;
      fall_n = WIDTH'(s1_c);
    end else begin
      rise_n = (s1_p >= s1_lo) ? WIDTH'(s1_p - s1_lo)
                               : WIDTH'(s1_p + s1_c - s1_lo);
      fall_n = (f_sum >= s1_c) ? WIDTH'(f_sum - s1_c) : WIDTH'(f_sum);
    end
  end

  // Stage 2 register: write the finished channel into the output arrays
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        RISE[i] <= '0;
        FALL[i] <= '0;
      end
    end else if (s1_vld) begin
      RISE[s1_ch] <= rise_n;
      FALL[s1_ch] <= fall_n;
    end
  end

endmodule

// File: tb/tb_pwm_preconditioner.sv
// Scoreboard bench for pwm_preconditioner: stimulus pushes the expected
// arrays and DOUT_VALID time per pass; a monitor pops them on DOUT_VALID.

module tb_pwm_preconditioner;

  localparam int W = 13;
  localparam int D = 249;

  logic         CLK = 1'b0;
  logic         RST;
  logic         DIN_VALID;
  logic [W-1:0] cyc_in   [0:D-1];
  logic [W-1:0] duty_in  [0:D-1];
  logic [W-1:0] phase_in [0:D-1];
  logic [W-1:0] rise_out [0:D-1];
  logic [W-1:0] fall_out [0:D-1];
  logic         dout_valid;

  pwm_preconditioner #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DIN_VALID (DIN_VALID),
    .CYCLE     (cyc_in),
    .DUTY      (duty_in),
    .PHASE     (phase_in),
    .RISE      (rise_out),
    .FALL      (fall_out),
    .DOUT_VALID(dout_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [D-1:0][W-1:0] r;
    logic [D-1:0][W-1:0] f;
    logic [31:0]         due;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   cyc     = 0;
  int   total   = 0;
  int   bad     = 0;
  int   n_pulse = 0;
  int   pass_no = 0;
  logic prev_dv = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: every DOUT_VALID pops one expected pass and checks it
  always @(negedge CLK) begin
    exp_t e;
    int   br, bf;
    if (dout_valid === 1'b1) begin
      n_pulse++;
      total++;
      if (prev_dv === 1'b1) begin
        bad++;
        $display("FAIL dv_back_to_back: got two consecutive pulses, want one");
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL dv_unexpected: got pulse at cycle %0d, want none", cyc);
      end else begin
        e = exp_q.pop_front();
        pass_no++;
        if (cyc != int'(e.due)) begin
          bad++;
          $display("FAIL latency pass%0d: got cycle %0d, want %0d", pass_no, cyc, e.due);
        end
        br = -1;
        bf = -1;
        for (int i = 0; i < D; i++) begin
          if (br < 0 && rise_out[i] !== e.r[i]) br = i;
          if (bf < 0 && fall_out[i] !== e.f[i]) bf = i;
        end
        total++;
        if (br >= 0) begin
          bad++;
          $display("FAIL rise pass%0d ch%0d: got %0d, want %0d", pass_no, br, rise_out[br], e.r[br]);
        end
        total++;
        if (bf >= 0) begin
          bad++;
          $display("FAIL fall pass%0d ch%0d: got %0d, want %0d", pass_no, bf, fall_out[bf], e.f[bf]);
        end
      end
    end
    prev_dv = dout_valid;
  end

  task automatic set_uniform(input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] p);
    for (int i = 0; i < D; i++) begin
      cyc_in[i]   = c;
      duty_in[i]  = d;
      phase_in[i] = p;
    end
  endtask

  task automatic set_chan(input int ch, input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] p);
    cyc_in[ch]   = c;
    duty_in[ch]  = d;
    phase_in[ch] = p;
  endtask

  task automatic fill_exp(input logic [W-1:0] r, input logic [W-1:0] f);
    for (int i = 0; i < D; i++) begin
      cur.r[i] = r;
      cur.f[i] = f;
    end
  endtask

  task automatic exp_chan(input int ch, input logic [W-1:0] r, input logic [W-1:0] f);
    cur.r[ch] = r;
    cur.f[ch] = f;
  endtask

  task automatic pulse_din(output int k);
    @(negedge CLK);
    DIN_VALID = 1'b1;
    k = cyc + 1;
    @(negedge CLK);
    DIN_VALID = 1'b0;
  endtask

  task automatic push_exp(input int due);
    cur.due = 32'(due);
    exp_q.push_back(cur);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2 * D + 50) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL dv_timeout: got %0d passes outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (5) @(negedge CLK);
  endtask

  task automatic check_all_zero(input string tag);
    int nz;
    nz = 0;
    for (int i = 0; i < D; i++)
      if (rise_out[i] !== '0 || fall_out[i] !== '0) nz++;
    total++;
    if (nz != 0) begin
      bad++;
      $display("FAIL %s_arrays: got %0d nonzero channels, want 0", tag, nz);
    end
    total++;
    if (dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_dv: got %b, want 0", tag, dout_valid);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1);
  end

  initial begin
    int k, k2, np0;
    RST       = 1'b1;
    DIN_VALID = 1'b0;
    set_uniform(13'd4096, 13'd0, 13'd0);
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // centred pulse, every channel
    set_uniform(13'd4096, 13'd2048, 13'd1024);
    fill_exp(13'd0, 13'd2048);
    pulse_din(k);
    push_exp(k + D + 3);
    wait_drain();

    // wrap, odd duty and boundary channels; the rest centred
    set_chan(0, 13'd4096, 13'd100,  13'd0);
    set_chan(1, 13'd4096, 13'd101,  13'd1000);
    set_chan(2, 13'd4096, 13'd0,    13'd500);
    set_chan(3, 13'd4096, 13'd4096, 13'd7);
    set_chan(4, 13'd4096, 13'd5000, 13'd300);
    set_chan(5, 13'd4096, 13'd2,    13'd4100);
    set_chan(6, 13'd0,    13'd50,   13'd3);
    set_chan(7, 13'd1000, 13'd999,  13'd1990);
    set_chan(8, 13'd8191, 13'd8190, 13'd8190);
    fill_exp(13'd0, 13'd2048);
    exp_chan(0, 13'd4046, 13'd50);
    exp_chan(1, 13'd950,  13'd1051);
    exp_chan(2, 13'd0,    13'd0);
    exp_chan(3, 13'd0,    13'd4096);
    exp_chan(4, 13'd0,    13'd4096);
    exp_chan(5, 13'd3,    13'd5);
    exp_chan(6, 13'd0,    13'd0);
    exp_chan(7, 13'd491,  13'd490);
    exp_chan(8, 13'd4095, 13'd4094);
    pulse_din(k);
    push_exp(k + D + 3);
    wait_drain();

    // pending: three strobes mid-run collapse into one extra back-to-back pass
    np0 = n_pulse;
    set_uniform(13'd4096, 13'd100, 13'd0);
    fill_exp(13'd4046, 13'd50);
    pulse_din(k);
    push_exp(k + D + 3);
    repeat (20) @(negedge CLK);
    pulse_din(k2);
    repeat (30) @(negedge CLK);
    pulse_din(k2);
    repeat (50) @(negedge CLK);
    pulse_din(k2);
    wait_until(k + D + 1);
    set_uniform(13'd4096, 13'd1000, 13'd3000);
    fill_exp(13'd2500, 13'd3500);
    push_exp(k + 2 * D + 7);
    wait_drain();
    repeat (D + 20) @(negedge CLK);
    total++;
    if (n_pulse - np0 != 2) begin
      bad++;
      $display("FAIL pending_pulses: got %0d, want 2", n_pulse - np0);
    end

    // reset at idx 100 aborts the pass
    np0 = n_pulse;
    set_uniform(13'd4096, 13'd2048, 13'd1024);
    pulse_din(k);
    wait_until(k + 100);
    total++;
    if (fall_out[0] !== 13'd2048) begin
      bad++;
      $display("FAIL partial_new ch0: got %0d, want 2048", fall_out[0]);
    end
    total++;
    if (fall_out[200] !== 13'd3500) begin
      bad++;
      $display("FAIL partial_old ch200: got %0d, want 3500", fall_out[200]);
    end
    #1 RST = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (D + 10) @(negedge CLK);
    total++;
    if (n_pulse != np0) begin
      bad++;
      $display("FAIL midrst_no_dv: got %0d pulses, want 0", n_pulse - np0);
    end

    // per-channel distinct values after reset: full normal pass
    for (int i = 0; i < D; i++) begin
      set_chan(i, 13'd4096, 13'd2, 13'(i));
      exp_chan(i, (i == 0) ? 13'd4095 : 13'(i - 1), 13'(i + 1));
    end
    pulse_din(k);
    push_exp(k + D + 3);
    wait_drain();

    repeat (10) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_preconditioner.md
Name: pwm_preconditioner

Overview:
- Sits directly downstream of the silencer stage and consumes its smoothed DUTY_S/PHASE_S arrays plus the per-transducer CYCLE array.
- Converts each (cycle, duty, phase) triple into rise/fall compare times for the per-transducer PWM generators.
- Processes one channel per clock through a 3-stage pipeline and pulses DOUT_VALID once the whole array is refreshed.

Parameters:
- WIDTH, 13, bit width of cycle/duty/phase/rise/fall values.
- DEPTH, 249, number of transducer channels.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous reset, active-high.
- DIN_VALID  input  1  one-cycle strobe; connected to the upstream OUT_VALID.
- CYCLE[0:DEPTH-1]  input  WIDTH each  PWM period per channel.
- DUTY[0:DEPTH-1]  input  WIDTH each  smoothed duty per channel.
- PHASE[0:DEPTH-1]  input  WIDTH each  smoothed phase per channel.
- RISE[0:DEPTH-1]  output  WIDTH each  registered rising-edge time.
- FALL[0:DEPTH-1]  output  WIDTH each  registered falling-edge time.
- DOUT_VALID  output  1  one-cycle pulse when all RISE/FALL entries have been rewritten.

Behaviour:
- Reset (async, active-high):
  - RISE, FALL, DOUT_VALID = 0.
  - FSM enters IDLE; channel index = 0; PENDING = 0.
  - Reset mid-run aborts the pass. No DOUT_VALID is issued, and partial updates stay as written until reset clears them.
- FSM states:
  - IDLE: sampling DIN_VALID=1 moves to RUN with idx=0.
  - RUN: idx increments each cycle. After issuing idx=DEPTH-1, moves to DRAIN.
  - DRAIN: waits 2 cycles for the pipeline to empty, asserts DOUT_VALID for 1 cycle, then goes to IDLE, or straight to RUN if PENDING.
- Pipeline:
  - S0 registers CYCLE[idx], DUTY[idx], PHASE[idx].
  - S1 clamps values and computes halves.
  - S2 wraps results and writes RISE[ch], FALL[ch].
- Latency: with DIN_VALID sampled high at edge k (in IDLE), RISE/FALL[0] are written at edge k+3, RISE/FALL[DEPTH-1] at edge k+DEPTH+2, and DOUT_VALID is high for the cycle following edge k+DEPTH+3.
- Outputs update in place, channel by channel. Consumers must treat the arrays as coherent only from DOUT_VALID until the next pass starts.
- Inputs are read live per channel. Upstream holds its outputs stable between its OUT_VALID strobes.
- Arithmetic (per channel, c=CYCLE, internal width WIDTH+1, unsigned):
  - p = (PHASE >= c) ? PHASE - c : PHASE.
  - d = (DUTY > c) ? c : DUTY.
  - d == 0: RISE = 0, FALL = 0 (always low).
  - d == c: RISE = 0, FALL = c (always high).
  - Otherwise: r = p - floor(d/2), adding c if negative; f = p + ceil(d/2), subtracting c if >= c.
  - c == 0: RISE = FALL = 0.
- Downstream rule, stated here for verification: for counter t in [0,c-1], output is high when RISE <= t < FALL if RISE <= FALL, else when t >= RISE or t < FALL.
- DIN_VALID while in RUN or DRAIN:
  - Sets PENDING; multiple strobes collapse into one.
  - After DOUT_VALID, the next pass starts with idx=0 on the following cycle and PENDING clears.
  - DIN_VALID coincident with the DOUT_VALID cycle also counts as pending.
- DOUT_VALID never asserts for two consecutive cycles.

Test Plan (WIDTH=13, c=4096 unless stated):
- Centered: DUTY=2048, PHASE=1024, all channels -> RISE=0, FALL=2048; DOUT_VALID exactly DEPTH+3 cycles after DIN_VALID, single pulse.
- Wrap and odd duty:
  - ch0 DUTY=100, PHASE=0 -> RISE=4046, FALL=50.
  - ch1 DUTY=101, PHASE=1000 -> RISE=950, FALL=1051.
- Boundary values:
  - DUTY=0 -> RISE=FALL=0.
  - DUTY=4096 or DUTY=5000 -> RISE=0, FALL=4096.
  - PHASE=4100, DUTY=2 -> RISE=3, FALL=5.
  - CYCLE=0 -> RISE=FALL=0.
- Per-channel distinctness: channel i gets PHASE=i, DUTY=2 -> RISE[i]=(i-1) mod 4096, FALL[i]=i+1; checks index/pipeline alignment across all 249 channels.
- Pending:
  - DIN_VALID strobed 3 times during RUN -> exactly one extra pass starts the cycle after the first DOUT_VALID; two DOUT_VALID pulses total.
  - New input values are reflected after the second pulse.
- Reset mid-run: assert RST at idx=100 -> all RISE/FALL=0 immediately, no DOUT_VALID. A subsequent DIN_VALID gives a normal full pass with the latency above.
